freelist_reclaim_arb: RTL and testbench
=======================================

# freelist_reclaim_arb

Arbiter and sequencer that shares the rename free list's single push port between two physical-register reclaim sources: the ROB commit path and the squash-walk path.
- Commit path: frees the previous mapping of each retiring destination.
- Squash-walk path: frees the destinations of squashed instructions during mispredict recovery.
- Each source gets a small FIFO. The block arbitrates one push per cycle into the free list, and raises a recovery-freeze flag to rename until all squashed registers are returned.

## Interface
- PREG_W, 6: physical register index width.
- BUF_DEPTH, 4: entries per source FIFO; power of two, at least 2.
- BUF_AW, 2: log2(BUF_DEPTH).

- CLK  in  1  clock; all state updates on rising edge.
- RESET  in  1  asynchronous, active-high reset.
- fROB_commitReq_IN  in  1  commit source offers a register this cycle.
- fROB_commitPreg_IN  in  PREG_W  register to free.
- tROB_commitStall_OUT  out  1  commit FIFO full; offer not accepted.
- fSQ_walkStart_IN  in  1  single-cycle pulse, recovery walk begins.
- fSQ_walkReq_IN  in  1  squash walker offers a register.
- fSQ_walkPreg_IN  in  PREG_W  register to free.
- fSQ_walkDone_IN  in  1  single-cycle pulse, walker issued its last offer (the same-cycle offer counts).
- tSQ_walkStall_OUT  out  1  squash FIFO full; offer not accepted.
- fFreeL_full_IN  in  1  free list cannot accept a push.
- tFreeL_pushReq_OUT  out  1  registered push strobe to the free list.
- tFreeL_pushData_OUT  out  PREG_W  registered push data.
- tREN_recovering_OUT  out  1  rename must hold (state RECOVER or DRAIN).
- tReclaimCount_OUT  out  16  total pushes issued, wraps at 2^16.

## Operation
- Offer acceptance: an offer is accepted when its req is high and its stall is low.
  - Stall = (registered FIFO count == BUF_DEPTH), combinational from the count only. A pop in the same cycle does not unstall.
- Register 0 is never freed. Accepted offers with preg == 0 are consumed and dropped, not buffered.
- Selection: each cycle with fFreeL_full_IN low and at least one FIFO non-empty, exactly one head is popped and registered to the push outputs.
- Selection policy:
  - NORMAL: round-robin. The pointer moves to the other source after each grant. Reset pointer = commit.
  - RECOVER and DRAIN: the squash FIFO has strict priority. Commit is served only when the squash FIFO is empty.
- FIFO behaviour:
  - Pointers wrap mod BUF_DEPTH.
  - Simultaneous push and pop on a non-full FIFO keeps the count unchanged.
  - FIFO order is preserved per source.
- FSM states: NORMAL, RECOVER, DRAIN.
  - NORMAL -> RECOVER on fSQ_walkStart_IN. If fSQ_walkDone_IN is also high that cycle, go directly to DRAIN.
  - RECOVER -> DRAIN on fSQ_walkDone_IN.
  - DRAIN -> NORMAL when the squash FIFO is empty and no squash push is pending in the output register.
  - DRAIN -> RECOVER on fSQ_walkStart_IN (a new recovery pre-empts the drain).
  - fSQ_walkStart_IN while in RECOVER: ignored.
  - fSQ_walkDone_IN outside RECOVER: ignored.
- Squash offers are accepted in any state; the walker protocol guarantees they only occur in RECOVER.
- tReclaimCount_OUT increments by one for every cycle tFreeL_pushReq_OUT is high.

## Timing
- Reset values:
  - All outputs 0; state NORMAL.
  - Both FIFOs empty; round-robin pointer = commit; count = 0.
  - RESET asserted mid-recovery aborts immediately. Buffered registers are discarded; the free list is rebuilt by its own reset.
- Latency:
  - Offer accepted in cycle N (written at edge N).
  - Eligible for selection in cycle N+1.
  - tFreeL_pushReq_OUT high in cycle N+2 with the data.
- Backpressure:
  - fFreeL_full_IN is sampled in the selection cycle. If high, nothing is popped and tFreeL_pushReq_OUT is 0 the following cycle.
  - A push already registered is not retracted.
- tFreeL_pushReq_OUT is high for exactly one cycle per freed register. It is never high on consecutive cycles for the same entry.
- tREN_recovering_OUT:
  - Rises the cycle after the fSQ_walkStart_IN edge.
  - Falls the cycle after the DRAIN -> NORMAL transition, so the last squash push is visible no later than the fall.
- Throughput: one push per cycle sustained while fFreeL_full_IN is low.

## Test plan
- Commit only: offer pregs 5, 6, 7 on consecutive cycles.
  - Pushes of 5, 6, 7 appear on cycles 2, 3, 4 after the first offer.
  - Count reaches 3; stall stays low.
- Round-robin: commit and squash FIFOs each preloaded with 4 entries, state NORMAL, fFreeL_full_IN low.
  - Pushes alternate commit, squash, commit, squash, and so on.
  - 5th commit offer stalls while that FIFO is full.
- Recovery: walkStart, then squash offers 10, 11, 12 with walkDone on 12, with a commit offer of 20 in the same window.
  - 10, 11, 12 are pushed before 20.
  - tREN_recovering_OUT is high from the cycle after walkStart until the cycle after 12 is pushed.
- Free list full: hold fFreeL_full_IN high for 3 cycles with both FIFOs non-empty.
  - No push and no pop while it is high.
  - Pushes resume the cycle after it falls, and no entries are lost.
- preg 0 plus reset: offer preg 0, then preg 9.
  - Only 9 is pushed.
  - Asserting RESET mid-RECOVER forces all outputs to 0, state NORMAL, FIFOs empty.

Source files
------------

// File: rtl/freelist_reclaim_arb_if.sv
// -----------------------------------------------------------------------------
// freelist_reclaim_arb_if
// Bundles the reclaim-source offers, the free-list push port and the rename
// status outputs of freelist_reclaim_arb.
//
// Signals:
//   fROB_commitReq_IN / fROB_commitPreg_IN   commit-path offer and register
//   tROB_commitStall_OUT                     commit FIFO full
//   fSQ_walkStart_IN / fSQ_walkDone_IN       recovery walk start/end pulses
//   fSQ_walkReq_IN / fSQ_walkPreg_IN         squash-walk offer and register
//   tSQ_walkStall_OUT                        squash FIFO full
//   fFreeL_full_IN                           free list cannot accept a push
//   tFreeL_pushReq_OUT / tFreeL_pushData_OUT registered push to the free list
//   tREN_recovering_OUT                      rename must hold
//   tReclaimCount_OUT                        total pushes issued (wraps)
//
// Modports:
//   slave  - the arbiter itself
//   master - the environment driving offers and consuming pushes
// -----------------------------------------------------------------------------
interface freelist_reclaim_arb_if #(
   parameter int PREG_W = 6
);
   logic              fROB_commitReq_IN;
   logic [PREG_W-1:0] fROB_commitPreg_IN;
   logic              tROB_commitStall_OUT;
   logic              fSQ_walkStart_IN;
   logic              fSQ_walkReq_IN;
   logic [PREG_W-1:0] fSQ_walkPreg_IN;
   logic              fSQ_walkDone_IN;
   logic              tSQ_walkStall_OUT;
   logic              fFreeL_full_IN;
   logic              tFreeL_pushReq_OUT;
   logic [PREG_W-1:0] tFreeL_pushData_OUT;
   logic              tREN_recovering_OUT;
   logic [15:0]       tReclaimCount_OUT;

   modport slave (
      input  fROB_commitReq_IN, fROB_commitPreg_IN,
      input  fSQ_walkStart_IN, fSQ_walkReq_IN, fSQ_walkPreg_IN, fSQ_walkDone_IN,
      input  fFreeL_full_IN,
      output tROB_commitStall_OUT, tSQ_walkStall_OUT,
      output tFreeL_pushReq_OUT, tFreeL_pushData_OUT,
      output tREN_recovering_OUT, tReclaimCount_OUT
   );

   modport master (
      output fROB_commitReq_IN, fROB_commitPreg_IN,
      output fSQ_walkStart_IN, fSQ_walkReq_IN, fSQ_walkPreg_IN, fSQ_walkDone_IN,
      output fFreeL_full_IN,
      input  tROB_commitStall_OUT, tSQ_walkStall_OUT,
      input  tFreeL_pushReq_OUT, tFreeL_pushData_OUT,
      input  tREN_recovering_OUT, tReclaimCount_OUT
   );
endinterface

// File: rtl/freelist_reclaim_arb.sv
// -----------------------------------------------------------------------------
// freelist_reclaim_arb
// Shares the rename free list's single push port between the ROB commit
// reclaim path and the squash-walk reclaim path. Each source feeds a small
// FIFO; one head per cycle is popped into a registered push. During a
// mispredict recovery (RECOVER/DRAIN) the squash FIFO has strict priority and
// rename is held until every squashed register has been pushed.
//
// Ports:
//   CLK    clock, rising edge
//   RESET  asynchronous active-high reset; discards all buffered registers
//   bus    freelist_reclaim_arb_if.slave (offers, free-list push, status)
// -----------------------------------------------------------------------------
module freelist_reclaim_arb #(
   parameter int PREG_W    = 6,
   parameter int BUF_DEPTH = 4,
   parameter int BUF_AW    = 2
) (
   input  logic                         CLK,
   input  logic                         RESET,
   freelist_reclaim_arb_if.slave        bus
);

   // Source index: bit 0 = commit, bit 1 = squash.
   localparam logic SRC_COMMIT = 1'b0;
   localparam logic SRC_SQUASH = 1'b1;

   localparam logic [BUF_AW:0] DEPTH_C = (BUF_AW+1)'(BUF_DEPTH);

   typedef enum logic [1:0] {
      ST_NORMAL  = 2'd0,
      ST_RECOVER = 2'd1,
      ST_DRAIN   = 2'd2
   } state_t;

   state_t state_q, state_d;

   logic [1:0]              req_w;
   logic [1:0]              stall_w;
   logic [1:0]              wr_en_w;
   logic [1:0]              rd_en_w;
   logic [1:0]              nonempty_w;
   logic [1:0][PREG_W-1:0]  wdata_w;
   logic [1:0][PREG_W-1:0]  head_w;

   logic                    sel_vld;
   logic                    sel_src;

   logic                    rr_q;
   logic                    push_req_q;
   logic [PREG_W-1:0]       push_data_q;
   logic                    push_src_q;
   logic [15:0]             reclaim_cnt_q;
   logic                    recovering_q;

   assign req_w      = {bus.fSQ_walkReq_IN, bus.fROB_commitReq_IN};
   assign wdata_w[0] = bus.fROB_commitPreg_IN;
   assign wdata_w[1] = bus.fSQ_walkPreg_IN;

   // Per-source FIFO.
   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_fifo
         logic [PREG_W-1:0] mem_q [BUF_DEPTH];
         logic [BUF_AW-1:0] wr_ptr_q;
         logic [BUF_AW-1:0] rd_ptr_q;
         logic [BUF_AW:0]   cnt_q;
         logic [BUF_AW:0]   cnt_d;

         // Stall looks only at the registered count, so a same-cycle pop
         // never opens a slot for the offer.
         assign stall_w[gi]    = (cnt_q == DEPTH_C);
         // Register 0 is consumed on acceptance but never buffered.
         assign wr_en_w[gi]    = req_w[gi] & ~stall_w[gi] & (wdata_w[gi] != '0);
         assign nonempty_w[gi] = (cnt_q != '0);
         assign head_w[gi]     = mem_q[rd_ptr_q];

         always_comb begin
            cnt_d = cnt_q;
            case ({wr_en_w[gi], rd_en_w[gi]})
               2'b10:   cnt_d = cnt_q + 1'b1;
               2'b01:   cnt_d = cnt_q - 1'b1;
               default: cnt_d = cnt_q;
            endcase
         end

         // Pointers wrap naturally because the depth is a power of two.
         always_ff @(posedge CLK or posedge RESET) begin
            if (RESET) begin
               wr_ptr_q <= '0;
               rd_ptr_q <= '0;
               cnt_q    <= '0;
            end else begin
               if (wr_en_w[gi]) wr_ptr_q <= wr_ptr_q + 1'b1;
               if (rd_en_w[gi]) rd_ptr_q <= rd_ptr_q + 1'b1;
               cnt_q <= cnt_d;
            end
         end

         // Storage carries no reset; validity is tracked by the count.
         always_ff @(posedge CLK) begin
            if (wr_en_w[gi]) mem_q[wr_ptr_q] <= wdata_w[gi];
         end
      end
   endgenerate

   // Head selection: squash-first while recovering, round-robin otherwise.
   always_comb begin
      sel_vld = 1'b0;
      sel_src = SRC_COMMIT;
      if (!bus.fFreeL_full_IN && (|nonempty_w)) begin
         sel_vld = 1'b1;
         if (state_q != ST_NORMAL) begin
            sel_src = nonempty_w[SRC_SQUASH] ? SRC_SQUASH : SRC_COMMIT;
         end else if (&nonempty_w) begin
            sel_src = rr_q;
         end else begin
            sel_src = nonempty_w[SRC_SQUASH] ? SRC_SQUASH : SRC_COMMIT;
         end
      end
      rd_en_w = {sel_vld & sel_src, sel_vld & ~sel_src};
   end

   // Output register doubles as the registered RAM read.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         push_req_q    <= 1'b0;
         push_data_q   <= '0;
         push_src_q    <= SRC_COMMIT;
         rr_q          <= SRC_COMMIT;
         reclaim_cnt_q <= '0;
      end else begin
         push_req_q <= sel_vld;
         if (sel_vld) begin
            push_data_q   <= head_w[sel_src];
            push_src_q    <= sel_src;
            reclaim_cnt_q <= reclaim_cnt_q + 16'd1;
            if (state_q == ST_NORMAL) rr_q <= ~sel_src;
         end
      end
   end

   // Recovery FSM: state register.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_q      <= ST_NORMAL;
         recovering_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         recovering_q <= (state_d != ST_NORMAL);
      end
   end

   // Recovery FSM: next state. DRAIN holds until the last squash register has
   // left both the FIFO and the output register.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_NORMAL: begin
            if (bus.fSQ_walkStart_IN)
               state_d = bus.fSQ_walkDone_IN ? ST_DRAIN : ST_RECOVER;
         end
         ST_RECOVER: begin
            if (bus.fSQ_walkDone_IN) state_d = ST_DRAIN;
         end
         ST_DRAIN: begin
            if (bus.fSQ_walkStart_IN)
               state_d = ST_RECOVER;
            else if (!nonempty_w[SRC_SQUASH] && !(push_req_q && (push_src_q == SRC_SQUASH)))
               state_d = ST_NORMAL;
         end
         default: state_d = ST_NORMAL;
      endcase
   end

   assign bus.tROB_commitStall_OUT = stall_w[SRC_COMMIT];
   assign bus.tSQ_walkStall_OUT    = stall_w[SRC_SQUASH];
   assign bus.tFreeL_pushReq_OUT   = push_req_q;
   assign bus.tFreeL_pushData_OUT  = push_data_q;
   assign bus.tREN_recovering_OUT  = recovering_q;
   assign bus.tReclaimCount_OUT    = reclaim_cnt_q;

endmodule

// File: tb/tb_freelist_reclaim_arb.sv
// -----------------------------------------------------------------------------
// tb_freelist_reclaim_arb
// Scoreboard bench for freelist_reclaim_arb: each test queues the pushes it
// expects (value and, where fixed, cycle) as it drives offers; a negedge
// monitor pops and compares every push the DUT issues.
// -----------------------------------------------------------------------------
module tb_freelist_reclaim_arb;
   localparam int PREG_W = 6;

   logic CLK   = 1'b0;
   logic RESET = 1'b1;
   always #5 CLK = ~CLK;

   freelist_reclaim_arb_if #(.PREG_W(PREG_W)) bus ();

   freelist_reclaim_arb #(
      .PREG_W   (PREG_W),
      .BUF_DEPTH(4),
      .BUF_AW   (2)
   ) dut (
      .CLK  (CLK),
      .RESET(RESET),
      .bus  (bus.slave)
   );

   typedef struct {
      logic [PREG_W-1:0] preg;
      int                at_cyc;   // -1 = any cycle
   } exp_t;

   exp_t sb_q[$];
   int   compared    = 0;
   int   mismatched  = 0;
   int   cyc         = 0;
   int   pushes_seen = 0;
   int   rec_lo      = -1;
   int   rec_hi      = -1;
   int   rec_end     = -1;

   always @(posedge CLK) cyc <= cyc + 1;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      if (obs !== exp) begin
         mismatched++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   // Push monitor and recovering-window checker.
   always @(negedge CLK) begin : mon
      exp_t e;
      if (!RESET) begin
         if (bus.tFreeL_pushReq_OUT) begin
            pushes_seen++;
            $display("push preg=%0d cycle=%0d count=%0d", bus.tFreeL_pushData_OUT, cyc,
                     bus.tReclaimCount_OUT);
            check_val("push_expected", 32'(sb_q.size() > 0), 32'd1);
            if (sb_q.size() > 0) begin
               e = sb_q.pop_front();
               check_val("push_data", 32'(bus.tFreeL_pushData_OUT), 32'(e.preg));
               if (e.at_cyc >= 0) check_val("push_cycle", cyc, e.at_cyc);
            end
            check_val("reclaim_count", 32'(bus.tReclaimCount_OUT), pushes_seen);
         end
         if (rec_lo >= 0 && cyc <= rec_end)
            check_val("recovering", 32'(bus.tREN_recovering_OUT),
                      32'((cyc >= rec_lo) && (cyc <= rec_hi)));
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic idle_inputs();
      bus.fROB_commitReq_IN  = 1'b0;
      bus.fROB_commitPreg_IN = '0;
      bus.fSQ_walkStart_IN   = 1'b0;
      bus.fSQ_walkReq_IN     = 1'b0;
      bus.fSQ_walkPreg_IN    = '0;
      bus.fSQ_walkDone_IN    = 1'b0;
      bus.fFreeL_full_IN     = 1'b0;
   endtask

   task automatic do_reset();
      idle_inputs();
      RESET = 1'b1;
      sb_q.delete();
      pushes_seen = 0;
      tick();
      tick();
      RESET = 1'b0;
      tick();
   endtask

   task automatic expect_push(input logic [PREG_W-1:0] p, input int at);
      exp_t e;
      e.preg   = p;
      e.at_cyc = at;
      sb_q.push_back(e);
   endtask

   task automatic wait_drain(input int budget);
      int n;
      n = 0;
      while (sb_q.size() > 0 && n < budget) begin
         tick();
         n++;
      end
      check_val("drain_timeout", sb_q.size(), 0);
   endtask

   int c0, f, s, a, b;

   initial begin
      idle_inputs();
      do_reset();

      // Reset state.
      check_val("rst_pushReq",   32'(bus.tFreeL_pushReq_OUT), 0);
      check_val("rst_pushData",  32'(bus.tFreeL_pushData_OUT), 0);
      check_val("rst_recovering",32'(bus.tREN_recovering_OUT), 0);
      check_val("rst_count",     32'(bus.tReclaimCount_OUT), 0);
      check_val("rst_cstall",    32'(bus.tROB_commitStall_OUT), 0);
      check_val("rst_wstall",    32'(bus.tSQ_walkStall_OUT), 0);

      // Commit only: 5, 6, 7 pushed two cycles after each offer.
      c0 = cyc;
      for (int i = 0; i < 3; i++) begin
         bus.fROB_commitReq_IN  = 1'b1;
         bus.fROB_commitPreg_IN = PREG_W'(5 + i);
         expect_push(PREG_W'(5 + i), c0 + 2 + i);
         check_val("t1_stall", 32'(bus.tROB_commitStall_OUT), 0);
         tick();
      end
      bus.fROB_commitReq_IN = 1'b0;
      wait_drain(10);
      tick();
      check_val("t1_count", 32'(bus.tReclaimCount_OUT), 3);

      // Round-robin: preload 4 + 4 behind a full free list, then release.
      do_reset();
      bus.fFreeL_full_IN = 1'b1;
      for (int i = 0; i < 4; i++) begin
         bus.fROB_commitReq_IN  = 1'b1;
         bus.fROB_commitPreg_IN = PREG_W'(30 + i);
         bus.fSQ_walkReq_IN     = 1'b1;
         bus.fSQ_walkPreg_IN    = PREG_W'(40 + i);
         tick();
      end
      bus.fSQ_walkReq_IN     = 1'b0;
      bus.fROB_commitPreg_IN = PREG_W'(63);
      check_val("t2_cstall_full", 32'(bus.tROB_commitStall_OUT), 1);
      check_val("t2_wstall_full", 32'(bus.tSQ_walkStall_OUT), 1);
      tick();
      bus.fROB_commitReq_IN = 1'b0;
      f = cyc;
      for (int i = 0; i < 4; i++) begin
         expect_push(PREG_W'(30 + i), f + 1 + 2 * i);
         expect_push(PREG_W'(40 + i), f + 2 + 2 * i);
      end
      bus.fFreeL_full_IN = 1'b0;
      wait_drain(20);
      tick();
      check_val("t2_cstall_after", 32'(bus.tROB_commitStall_OUT), 0);

      // Recovery: squash 10, 11, 12 ahead of commit 20.
      do_reset();
      s = cyc;
      rec_lo  = s + 1;
      rec_hi  = s + 6;
      rec_end = s + 10;
      expect_push(PREG_W'(10), s + 3);
      expect_push(PREG_W'(11), s + 4);
      expect_push(PREG_W'(12), s + 5);
      expect_push(PREG_W'(20), s + 6);
      bus.fSQ_walkStart_IN = 1'b1;
      tick();
      bus.fSQ_walkStart_IN   = 1'b0;
      bus.fSQ_walkReq_IN     = 1'b1;
      bus.fSQ_walkPreg_IN    = PREG_W'(10);
      bus.fROB_commitReq_IN  = 1'b1;
      bus.fROB_commitPreg_IN = PREG_W'(20);
      tick();
      bus.fROB_commitReq_IN = 1'b0;
      bus.fSQ_walkPreg_IN   = PREG_W'(11);
      tick();
      bus.fSQ_walkPreg_IN = PREG_W'(12);
      bus.fSQ_walkDone_IN = 1'b1;
      tick();
      bus.fSQ_walkReq_IN  = 1'b0;
      bus.fSQ_walkDone_IN = 1'b0;
      wait_drain(20);
      while (cyc <= rec_end + 1) tick();
      rec_lo = -1;

      // Free list full for 3 cycles with both FIFOs non-empty.
      do_reset();
      a = cyc;
      expect_push(PREG_W'(50), a + 2);
      expect_push(PREG_W'(60), a + 6);
      expect_push(PREG_W'(51), a + 7);
      expect_push(PREG_W'(61), a + 8);
      expect_push(PREG_W'(52), a + 9);
      expect_push(PREG_W'(62), a + 10);
      for (int i = 0; i < 3; i++) begin
         bus.fROB_commitReq_IN  = 1'b1;
         bus.fROB_commitPreg_IN = PREG_W'(50 + i);
         bus.fSQ_walkReq_IN     = 1'b1;
         bus.fSQ_walkPreg_IN    = PREG_W'(60 + i);
         if (i == 2) bus.fFreeL_full_IN = 1'b1;
         tick();
      end
      bus.fROB_commitReq_IN = 1'b0;
      bus.fSQ_walkReq_IN    = 1'b0;
      tick();
      tick();
      bus.fFreeL_full_IN = 1'b0;
      wait_drain(20);

      // Register 0 dropped, then reset mid-recovery.
      do_reset();
      b = cyc;
      bus.fROB_commitReq_IN  = 1'b1;
      bus.fROB_commitPreg_IN = '0;
      tick();
      bus.fROB_commitPreg_IN = PREG_W'(9);
      expect_push(PREG_W'(9), b + 3);
      tick();
      bus.fROB_commitReq_IN = 1'b0;
      wait_drain(10);
      tick();
      check_val("t5_count", 32'(bus.tReclaimCount_OUT), 1);

      bus.fSQ_walkStart_IN = 1'b1;
      tick();
      bus.fSQ_walkStart_IN = 1'b0;
      check_val("t5_recovering", 32'(bus.tREN_recovering_OUT), 1);
      bus.fFreeL_full_IN     = 1'b1;
      bus.fSQ_walkReq_IN     = 1'b1;
      bus.fSQ_walkPreg_IN    = PREG_W'(15);
      bus.fROB_commitReq_IN  = 1'b1;
      bus.fROB_commitPreg_IN = PREG_W'(16);
      tick();
      bus.fSQ_walkReq_IN    = 1'b0;
      bus.fROB_commitReq_IN = 1'b0;
      tick();
      #2;
      RESET = 1'b1;
      #1;
      check_val("t5_rst_pushReq",    32'(bus.tFreeL_pushReq_OUT), 0);
      check_val("t5_rst_pushData",   32'(bus.tFreeL_pushData_OUT), 0);
      check_val("t5_rst_recovering", 32'(bus.tREN_recovering_OUT), 0);
      check_val("t5_rst_count",      32'(bus.tReclaimCount_OUT), 0);
      pushes_seen = 0;
      sb_q.delete();
      tick();
      RESET = 1'b0;
      bus.fFreeL_full_IN = 1'b0;
      repeat (6) tick();
      check_val("t5_post_recovering", 32'(bus.tREN_recovering_OUT), 0);
      check_val("t5_post_count",      32'(bus.tReclaimCount_OUT), 0);
      check_val("t5_post_cstall",     32'(bus.tROB_commitStall_OUT), 0);

      check_val("sb_empty", sb_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
